// File: rtl/frogger_game_seq.sv
// ---------------------------------------------------------------------------
// frogger_game_seq
//
// Game sequencer for a Frogger-style game. It tracks the overall game state
// (idle, playing, dying, level-up, game over), lives, level, the per-life
// countdown timer and the lily-pad occupancy bitmap. The frog datapath reports
// collisions, drownings and pad arrivals. This block decides what happens
// next and tells the datapath when to move and when to send the frog home.
//
// Parameters
//   c_TICK_COUNT  : clock cycles per game tick
//   c_ROUND_TIME  : ticks allowed per life (1..31)
//   c_HOLD_TICKS  : ticks spent frozen in DYING / LEVEL_UP (>=1)
//   c_START_LIVES : lives at game start (1..3)
//
// Ports
//   i_Clk          in   system clock
//   i_Rst          in   synchronous reset, active-high
//   i_Start        in   start button level (edge detected here)
//   i_Collided     in   frog hit a vehicle
//   i_Drowned      in   frog in water, not on a log
//   i_Pad_Reached  in   one-cycle pulse: frog entered the top row
//   i_Pad_Index    in   lily pad index for i_Pad_Reached
//   o_Game_Active  out  high only in PLAY, enables frog movement
//   o_Frog_Reset   out  one-cycle pulse returning frog to origin
//   o_Lives        out  remaining lives
//   o_Level        out  current level
//   o_Time_Left    out  remaining ticks this life
//   o_Pads_Filled  out  bitmap of occupied lily pads
//   o_State        out  encoded state (0 idle .. 4 game over)
//   o_Game_Over    out  high only in GAME_OVER
// ---------------------------------------------------------------------------
module frogger_game_seq #(
  parameter int c_TICK_COUNT  = 25000000,
  parameter int c_ROUND_TIME  = 30,
  parameter int c_HOLD_TICKS  = 2,
  parameter int c_START_LIVES = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Collided,
  input  logic       i_Drowned,
  input  logic       i_Pad_Reached,
  input  logic [2:0] i_Pad_Index,
  output logic       o_Game_Active,
  output logic       o_Frog_Reset,
  output logic [1:0] o_Lives,
  output logic [3:0] o_Level,
  output logic [4:0] o_Time_Left,
  output logic [4:0] o_Pads_Filled,
  output logic [2:0] o_State,
  output logic       o_Game_Over
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PLAY      = 3'd1;
  localparam logic [2:0] ST_DYING     = 3'd2;
  localparam logic [2:0] ST_LEVEL_UP  = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  localparam int TICK_W = (c_TICK_COUNT > 1) ? $clog2(c_TICK_COUNT) : 1;
  localparam int HOLD_W = $clog2(c_HOLD_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(c_TICK_COUNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(c_HOLD_TICKS - 1);
  localparam logic [4:0]        ROUND_TIME = 5'(c_ROUND_TIME);
  localparam logic [1:0]        START_LIVES = 2'(c_START_LIVES);

  logic [2:0]        state, state_nxt;
  logic              start_prev;
  logic [TICK_W-1:0] tick_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        lives, lives_nxt;
  logic [3:0]        level, level_nxt;
  logic [4:0]        time_left, time_left_nxt;
  logic [4:0]        pads, pads_nxt;
  logic              frog_reset, frog_reset_req;

  logic              start_edge;
  logic              tick;
  logic              hold_done;
  logic              pad_in_range;
  logic [4:0]        pad_mask;
  logic              pad_taken;
  logic              timeout;
  logic              death;
  logic              pad_valid;

  // Event decode shared by the next-state logic. The pad mask is built by
  // shifting rather than indexing so out-of-range indices simply give an
  // empty mask.
  always_comb begin
    start_edge   = i_Start & ~start_prev;
    tick         = (tick_cnt == TICK_LAST);
    hold_done    = tick && (hold_cnt == HOLD_LAST);
    pad_in_range = (i_Pad_Index <= 3'd4);
    pad_mask     = pad_in_range ? (5'b00001 << i_Pad_Index) : 5'b00000;
    pad_taken    = |(pads & pad_mask);
    timeout      = tick && (time_left == 5'd1);
    death        = i_Collided | i_Drowned | timeout |
                   (i_Pad_Reached & (~pad_in_range | pad_taken));
    pad_valid    = i_Pad_Reached & pad_in_range & ~pad_taken & ~death;
  end

  // Next-state and next-value logic for all game registers. Frog-reset
  // requests are gathered here and gated against the current pulse at the
  // end, so the pulse can never stretch across two cycles even if two
  // triggering events land back to back.
  always_comb begin
    state_nxt      = state;
    lives_nxt      = lives;
    level_nxt      = level;
    time_left_nxt  = time_left;
    pads_nxt       = pads;
    frog_reset_req = 1'b0;

    case (state)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_edge) begin
          state_nxt      = ST_PLAY;
          lives_nxt      = START_LIVES;
          level_nxt      = 4'd1;
          pads_nxt       = 5'b00000;
          time_left_nxt  = ROUND_TIME;
          frog_reset_req = 1'b1;
        end
      end

      ST_PLAY: begin
        if (tick) begin
          time_left_nxt = time_left - 5'd1;
        end
        if (death) begin
          state_nxt = ST_DYING;
          lives_nxt = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
        end else if (pad_valid) begin
          pads_nxt       = pads | pad_mask;
          time_left_nxt  = ROUND_TIME;
          frog_reset_req = 1'b1;
          if ((pads | pad_mask) == 5'b11111) begin
            state_nxt = ST_LEVEL_UP;
          end
        end
      end

      ST_DYING: begin
        if (hold_done) begin
          if (lives == 2'd0) begin
            state_nxt = ST_GAME_OVER;
          end else begin
            state_nxt      = ST_PLAY;
            time_left_nxt  = ROUND_TIME;
            frog_reset_req = 1'b1;
          end
        end
      end

      ST_LEVEL_UP: begin
        if (hold_done) begin
          state_nxt      = ST_PLAY;
          pads_nxt       = 5'b00000;
          level_nxt      = (level == 4'd15) ? 4'd15 : level + 4'd1;
          time_left_nxt  = ROUND_TIME;
          frog_reset_req = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Game registers. Reset parks the game in IDLE and primes the start-edge
  // detector high so a button held through reset cannot launch a game.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= ST_IDLE;
      start_prev <= 1'b1;
      lives      <= START_LIVES;
      level      <= 4'd0;
      time_left  <= ROUND_TIME;
      pads       <= 5'b00000;
      frog_reset <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_prev <= i_Start;
      lives      <= lives_nxt;
      level      <= level_nxt;
      time_left  <= time_left_nxt;
      pads       <= pads_nxt;
      frog_reset <= frog_reset_req & ~frog_reset;
    end
  end

  // Tick prescaler and hold counter. Both restart on any state change so
  // every state begins with a full tick period and a fresh hold count.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tick_cnt <= '0;
      hold_cnt <= '0;
    end else if (state_nxt != state) begin
      tick_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick && (state == ST_DYING || state == ST_LEVEL_UP)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign o_Game_Active = (state == ST_PLAY);
  assign o_Game_Over   = (state == ST_GAME_OVER);
  assign o_Frog_Reset  = frog_reset;
  assign o_Lives       = lives;
  assign o_Level       = level;
  assign o_Time_Left   = time_left;
  assign o_Pads_Filled = pads;
  assign o_State       = state;

endmodule

// File: tb/tb_frogger_game_seq.sv
// ---------------------------------------------------------------------------
// tb_frogger_game_seq
//
// Directed bench for frogger_game_seq with a 4-cycle tick, 3-tick rounds,
// 2-tick holds and 3 starting lives. Inputs change and outputs are sampled
// on the falling clock edge; each step advances one rising edge.
// ---------------------------------------------------------------------------
module tb_frogger_game_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       collided;
  logic       drowned;
  logic       pad_reached;
  logic [2:0] pad_index;
  logic       game_active;
  logic       frog_reset;
  logic [1:0] lives;
  logic [3:0] level;
  logic [4:0] time_left;
  logic [4:0] pads_filled;
  logic [2:0] state;
  logic       game_over;

  int assertCount = 0;
  int failCount   = 0;
  logic [4:0] expPads;

  frogger_game_seq #(
    .c_TICK_COUNT (4),
    .c_ROUND_TIME (3),
    .c_HOLD_TICKS (2),
    .c_START_LIVES(3)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Start      (start),
    .i_Collided   (collided),
    .i_Drowned    (drowned),
    .i_Pad_Reached(pad_reached),
    .i_Pad_Index  (pad_index),
    .o_Game_Active(game_active),
    .o_Frog_Reset (frog_reset),
    .o_Lives      (lives),
    .o_Level      (level),
    .o_Time_Left  (time_left),
    .o_Pads_Filled(pads_filled),
    .o_State      (state),
    .o_Game_Over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic c, input logic d,
                               input logic pr, input logic [2:0] pi);
    start       = s;
    collided    = c;
    drowned     = d;
    pad_reached = pr;
    pad_index   = pi;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // Collide once, ride out the DYING hold and check where the game lands.
  task automatic collideAndHold(input int expLives, input int expState,
                                input int expFrog);
    collided = 1'b1;
    waitCycles(1);
    checkOutput("death_state", state, 2);
    checkOutput("death_lives", lives, expLives);
    waitCycles(6);
    collided = 1'b0;
    waitCycles(1);
    checkOutput("hold_state", state, 2);
    checkOutput("hold_lives_ignore_collide", lives, expLives);
    waitCycles(1);
    checkOutput("after_hold_state", state, expState);
    checkOutput("after_hold_frog", frog_reset, expFrog);
  endtask

  task automatic holdThrough(input int expState);
    waitCycles(7);
    checkOutput("hold_mid_state", state, state === 3'd3 ? 3 : 2);
    waitCycles(1);
    checkOutput("hold_exit_state", state, expState);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    waitCycles(2);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_lives", lives, 3);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_time", time_left, 3);
    checkOutput("rst_pads", pads_filled, 0);
    checkOutput("rst_frog", frog_reset, 0);
    checkOutput("rst_active", game_active, 0);

    // Start held through reset must not launch a game
    rst = 1'b0;
    waitCycles(2);
    checkOutput("held_start_idle", state, 0);

    $display("[TB] start scenario");
    start = 1'b0;
    waitCycles(1);
    start = 1'b1;
    waitCycles(1);
    checkOutput("start_state", state, 1);
    checkOutput("start_lives", lives, 3);
    checkOutput("start_level", level, 1);
    checkOutput("start_time", time_left, 3);
    checkOutput("start_frog", frog_reset, 1);
    checkOutput("start_active", game_active, 1);
    waitCycles(1);
    checkOutput("start_frog_once", frog_reset, 0);

    $display("[TB] timeout scenario");
    waitCycles(2);
    checkOutput("time_before_tick", time_left, 3);
    waitCycles(1);
    checkOutput("time_tick1", time_left, 2);
    checkOutput("held_start_no_pulse", frog_reset, 0);
    waitCycles(4);
    checkOutput("time_tick2", time_left, 1);
    waitCycles(3);
    checkOutput("time_pre_timeout_state", state, 1);
    waitCycles(1);
    checkOutput("timeout_state", state, 2);
    checkOutput("timeout_lives", lives, 2);
    checkOutput("timeout_active", game_active, 0);
    // Start edge during DYING is ignored
    start = 1'b0;
    waitCycles(1);
    start = 1'b1;
    waitCycles(1);
    checkOutput("dying_ignore_start", state, 2);
    waitCycles(5);
    checkOutput("dying_time_held", time_left, 0);
    waitCycles(1);
    checkOutput("revive_state", state, 1);
    checkOutput("revive_time", time_left, 3);
    checkOutput("revive_frog", frog_reset, 1);
    waitCycles(1);
    checkOutput("revive_frog_once", frog_reset, 0);

    $display("[TB] game over scenario");
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    start = 1'b0;
    waitCycles(1);
    start = 1'b1;
    waitCycles(1);
    start = 1'b0;
    checkOutput("go_start_state", state, 1);
    collideAndHold(2, 1, 1);
    collideAndHold(1, 1, 1);
    collideAndHold(0, 4, 0);
    checkOutput("go_flag", game_over, 1);
    checkOutput("go_active", game_active, 0);
    start = 1'b1;
    waitCycles(1);
    checkOutput("restart_state", state, 1);
    checkOutput("restart_lives", lives, 3);
    checkOutput("restart_level", level, 1);
    checkOutput("restart_frog", frog_reset, 1);
    checkOutput("restart_go_flag", game_over, 0);
    start = 1'b0;

    $display("[TB] pads and level scenario");
    expPads = 5'b00000;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'(k));
      waitCycles(1);
      pad_reached = 1'b0;
      expPads = expPads | (5'b00001 << k);
      checkOutput("pad_bitmap", pads_filled, expPads);
      if (k < 4) begin
        checkOutput("pad_state_play", state, 1);
        waitCycles(1);
      end
    end
    checkOutput("levelup_state", state, 3);
    checkOutput("levelup_frog", frog_reset, 1);
    holdThrough(1);
    checkOutput("level2_pads", pads_filled, 0);
    checkOutput("level2_level", level, 2);
    checkOutput("level2_time", time_left, 3);
    checkOutput("level2_frog", frog_reset, 1);

    $display("[TB] conflict scenario");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    waitCycles(1);
    pad_reached = 1'b0;
    checkOutput("pad2_first", pads_filled, 5'b00100);
    checkOutput("pad2_first_lives", lives, 3);
    waitCycles(1);
    pad_reached = 1'b1;
    waitCycles(1);
    pad_reached = 1'b0;
    checkOutput("pad2_repeat_state", state, 2);
    checkOutput("pad2_repeat_lives", lives, 2);
    checkOutput("pad2_repeat_pads", pads_filled, 5'b00100);
    holdThrough(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 3'd0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput("collide_pad_state", state, 2);
    checkOutput("collide_pad_lives", lives, 1);
    checkOutput("collide_pad_bit_clear", pads_filled, 5'b00100);
    holdThrough(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
    waitCycles(1);
    pad_reached = 1'b0;
    checkOutput("pad6_state", state, 2);
    checkOutput("pad6_lives", lives, 0);

    $display("[TB] reset mid-dying scenario");
    waitCycles(3);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    checkOutput("midrst_state", state, 0);
    checkOutput("midrst_lives", lives, 3);
    checkOutput("midrst_level", level, 0);
    checkOutput("midrst_pads", pads_filled, 0);
    checkOutput("midrst_frog", frog_reset, 0);
    waitCycles(1);
    checkOutput("midrst_frog_next", frog_reset, 0);
    waitCycles(6);
    checkOutput("midrst_state_later", state, 0);
    checkOutput("midrst_frog_later", frog_reset, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/frogger_game_seq.md
FROGGER_GAME_SEQ -- requirements
Module: frogger_game_seq

Interface
REQ-001 The block SHALL provide these parameters:
- c_TICK_COUNT, 25000000, clock cycles per game tick (1 s).
- c_ROUND_TIME, 30, ticks allowed per life (1..31).
- c_HOLD_TICKS, 2, ticks frozen in DYING and LEVEL_UP (>=1).
- c_START_LIVES, 3, lives at game start (1..3).

REQ-002 The block SHALL provide these ports:
- i_Clk, in, 1, single system clock.
- i_Rst, in, 1, synchronous reset, active-high.
- i_Start, in, 1, start button level; rising edge detected internally.
- i_Collided, in, 1, vehicle collision from frog datapath.
- i_Drowned, in, 1, frog in water and not on a log.
- i_Pad_Reached, in, 1, frog entered top row this cycle (one-cycle pulse).
- i_Pad_Index, in, 3, lily pad index 0..4 for i_Pad_Reached.
- o_Game_Active, out, 1, enables frog movement datapath.
- o_Frog_Reset, out, 1, one-cycle pulse returning the frog to its origin.
- o_Lives, out, 2, remaining lives.
- o_Level, out, 4, current level.
- o_Time_Left, out, 5, remaining ticks this life.
- o_Pads_Filled, out, 5, bitmap of occupied lily pads.
- o_State, out, 3, encoded state (IDLE=0, PLAY=1, DYING=2, LEVEL_UP=3, GAME_OVER=4).
- o_Game_Over, out, 1, high while in GAME_OVER.

Function
REQ-003 The block SHALL detect a start edge as i_Start=1 while the registered previous i_Start=0.
REQ-004 The block SHALL use a tick counter (0..c_TICK_COUNT-1) that cleared on every state change and produces a tick strobe on the cycle it wraps.
REQ-005 o_Game_Active SHALL be 1 only in PLAY. o_Game_Over SHALL be 1 only in GAME_OVER.
REQ-006 In IDLE and GAME_OVER, a start edge SHALL, in the next cycle, cause all of the following:
- state = PLAY
- o_Lives = c_START_LIVES
- o_Level = 1
- o_Pads_Filled = 0
- o_Time_Left = c_ROUND_TIME
- o_Frog_Reset pulsed for one cycle
REQ-007 In PLAY, each tick strobe SHALL decrement o_Time_Left by 1. A decrement reaching 0 SHALL be a death event.
REQ-008 In PLAY, i_Collided=1 or i_Drowned=1 SHALL be a death event.
REQ-009 In PLAY, i_Pad_Reached=1 with i_Pad_Index<=4 and the corresponding bit clear SHALL cause the following:
- set that bit
- reload o_Time_Left to c_ROUND_TIME
- pulse o_Frog_Reset
REQ-010 In PLAY, i_Pad_Reached=1 with the indexed bit already set, or with i_Pad_Index>=5, SHALL be a death event.
REQ-011 When a death event and a valid pad arrival occur in the same cycle, the death event SHALL take priority and the pad bit SHALL NOT be set.
REQ-012 On a death event, the next cycle SHALL have state = DYING, o_Lives decremented by 1 (floor 0), and o_Pads_Filled unchanged.
REQ-013 DYING SHALL last exactly c_HOLD_TICKS tick strobes, then:
- if o_Lives=0, go to GAME_OVER;
- otherwise go to PLAY with o_Time_Left reloaded and o_Frog_Reset pulsed.
REQ-014 A valid pad arrival that sets the fifth bit (bitmap becomes 5'b11111) SHALL enter LEVEL_UP next cycle.
REQ-015 LEVEL_UP SHALL hold c_HOLD_TICKS tick strobes, then go to PLAY with all of the following:
- o_Pads_Filled = 0
- o_Level incremented, saturating at 15
- o_Time_Left reloaded
- o_Frog_Reset pulsed
REQ-016 Collision, drown and pad inputs SHALL be ignored outside PLAY. Start edges SHALL be ignored in PLAY, DYING and LEVEL_UP.
REQ-017 o_Time_Left SHALL hold its value outside PLAY, except when it is reloaded as specified above.
REQ-018 o_Frog_Reset SHALL never be high for two consecutive cycles.

Reset
REQ-019 While i_Rst=1 at a clock edge, the block SHALL set:
- state = IDLE
- tick counter = 0
- o_Lives = c_START_LIVES
- o_Level = 0
- o_Time_Left = c_ROUND_TIME
- o_Pads_Filled = 0
- all pulses and flags = 0
- registered previous i_Start = 1, so a button held through reset does not start a game
REQ-020 Reset asserted in any state, mid-hold or mid-tick, SHALL override all other activity in that cycle.

Verification (c_TICK_COUNT=4, c_ROUND_TIME=3, c_HOLD_TICKS=2, c_START_LIVES=3)
REQ-021 The bench SHALL cover these directed scenarios:
- Start: reset, then i_Start 0->1 -> one cycle later state=1, lives=3, level=1, time=3, one-cycle o_Frog_Reset; holding i_Start gives no further pulse.
- Timeout: PLAY with no input -> time 3,2,1 at 4-cycle spacing; the next tick gives state=2, lives=2; 8 cycles later state=1, time=3, o_Frog_Reset pulse.
- Game over: three collisions, each after its DYING hold -> lives 2,1,0; state=4 and o_Game_Over=1 after the last hold; a start edge returns state=1, lives=3, level=1.
- Pads/level: pad indices 0..4 in PLAY -> bitmap grows to 5'b11111 and state=3; after 8 cycles state=1, pads=0, level=2, time=3.
- Conflicts: pad index 2 twice -> second is a death (lives-1); i_Collided together with a valid pad in the same cycle -> death, bit stays clear; pad index 6 -> death.
- Reset mid-DYING: i_Rst during hold -> state=0, lives=3, level=0, pads=0 next cycle; no o_Frog_Reset pulse.
